// File: rtl/csr_access_arbiter.sv
// Two-port CSR access sequencer: arbitrates commit and debug requests onto the
// single CSR-file port and runs each access as a checked read-modify-write.
module csr_access_arbiter #(
    parameter int XLEN           = 64,
    parameter bit DBG_PRV_BYPASS = 1'b1
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic [1:0]      priv_i,

    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [11:0]     req0_addr_i,
    input  logic [1:0]      req0_op_i,
    input  logic [XLEN-1:0] req0_wdata_i,
    output logic            resp0_valid_o,
    input  logic            resp0_ready_i,
    output logic [XLEN-1:0] resp0_rdata_o,
    output logic            resp0_illegal_o,

    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [11:0]     req1_addr_i,
    input  logic [1:0]      req1_op_i,
    input  logic [XLEN-1:0] req1_wdata_i,
    output logic            resp1_valid_o,
    input  logic            resp1_ready_i,
    output logic [XLEN-1:0] resp1_rdata_o,
    output logic            resp1_illegal_o,

    output logic [11:0]     csr_addr_o,
    output logic            csr_rd_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    input  logic            csr_nonexist_i,
    output logic            csr_we_o,
    output logic [XLEN-1:0] csr_wdata_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;

    logic [1:0]      state;
    logic            owner;
    logic            last_grant;
    logic [11:0]     addr_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] old_q;
    logic            illegal_q;

    logic            any_valid;
    logic            grant;
    logic            resp_ready;
    logic            illegal_now;
    logic            priv_checked;
    logic [XLEN-1:0] write_value;

    // Round robin only matters when both ports ask at once.
    always_comb begin
        any_valid = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid_i;
        end
    end

    // Ready is gated by the reset pin so every output is low while reset is held.
    assign req0_ready_o = arst_i & (state == ST_IDLE) & req0_valid_i & ~grant;
    assign req1_ready_o = arst_i & (state == ST_IDLE) & req1_valid_i & grant;

    assign resp_ready   = owner ? resp1_ready_i : resp0_ready_i;
    assign priv_checked = ~(owner & DBG_PRV_BYPASS);

    always_comb begin
        illegal_now = csr_nonexist_i
                    | ((op_q != OP_READ) && (addr_q[11:10] == 2'b11))
                    | (priv_checked && (addr_q[9:8] > priv_i));
    end

    always_comb begin
        case (op_q)
            OP_RW:   write_value = wdata_q;
            OP_RS:   write_value = old_q | wdata_q;
            default: write_value = old_q & ~wdata_q;
        endcase
    end

    // Accept in IDLE, sample and judge in READ, optional write, then hold the response.
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            op_q       <= OP_READ;
            wdata_q    <= '0;
            old_q      <= '0;
            illegal_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        owner      <= grant;
                        last_grant <= grant;
                        addr_q     <= grant ? req1_addr_i  : req0_addr_i;
                        op_q       <= grant ? req1_op_i    : req0_op_i;
                        wdata_q    <= grant ? req1_wdata_i : req0_wdata_i;
                        state      <= ST_READ;
                    end
                end
                ST_READ: begin
                    old_q     <= illegal_now ? '0 : csr_rdata_i;
                    illegal_q <= illegal_now;
                    state     <= (illegal_now || op_q == OP_READ) ? ST_RESP : ST_WRITE;
                end
                ST_WRITE: begin
                    state <= ST_RESP;
                end
                default: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        csr_rd_o        = (state == ST_READ);
        csr_we_o        = (state == ST_WRITE);
        csr_addr_o      = (csr_rd_o || csr_we_o) ? addr_q : 12'h000;
        csr_wdata_o     = csr_we_o ? write_value : '0;
        resp0_valid_o   = (state == ST_RESP) && !owner;
        resp1_valid_o   = (state == ST_RESP) && owner;
        resp0_rdata_o   = resp0_valid_o ? old_q : '0;
        resp1_rdata_o   = resp1_valid_o ? old_q : '0;
        resp0_illegal_o = resp0_valid_o & illegal_q;
        resp1_illegal_o = resp1_valid_o & illegal_q;
    end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Bench for csr_access_arbiter: a transaction-timeline model checks every output each
// cycle while directed scenarios and random traffic drive both ports.
module tb_csr_access_arbiter;

    localparam logic [11:0] NONEXIST_ADDR = 12'h7C5;
    localparam logic [11:0] ADDRS [8] = '{12'h340, 12'h300, 12'hF14, 12'h100,
                                          12'h041, 12'h7C5, 12'hC00, 12'h305};

    logic        clk = 1'b0;
    logic        arst_i = 1'b0;
    logic [1:0]  priv = 2'b11;
    int          cyc = 0;

    logic        req_valid [2];
    logic [1:0]  req_op [2];
    logic [11:0] req_addr [2];
    logic [63:0] req_wdata [2];
    logic        resp_ready [2];

    logic        req0_ready, req1_ready;
    logic        rv [2];
    logic [63:0] rdat [2];
    logic        rill [2];
    logic [63:0] resp0_rdata, resp1_rdata;
    logic        resp0_valid, resp1_valid, resp0_illegal, resp1_illegal;
    logic [11:0] csr_addr;
    logic        csr_rd, csr_we, csr_nonexist;
    logic [63:0] csr_rdata, csr_wdata;

    logic [63:0] env_mem [4096];
    logic [63:0] model_mem [4096];

    int n_cmp = 0;
    int n_bad = 0;
    int we_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign rv[0] = resp0_valid;  assign rv[1] = resp1_valid;
    assign rdat[0] = resp0_rdata; assign rdat[1] = resp1_rdata;
    assign rill[0] = resp0_illegal; assign rill[1] = resp1_illegal;
    assign csr_rdata = env_mem[csr_addr];
    assign csr_nonexist = (csr_addr == NONEXIST_ADDR);

    csr_access_arbiter #(.XLEN(64), .DBG_PRV_BYPASS(1'b1)) dut (
        .clk_i(clk), .arst_i(arst_i), .priv_i(priv),
        .req0_valid_i(req_valid[0]), .req0_ready_o(req0_ready), .req0_addr_i(req_addr[0]),
        .req0_op_i(req_op[0]), .req0_wdata_i(req_wdata[0]),
        .resp0_valid_o(resp0_valid), .resp0_ready_i(resp_ready[0]),
        .resp0_rdata_o(resp0_rdata), .resp0_illegal_o(resp0_illegal),
        .req1_valid_i(req_valid[1]), .req1_ready_o(req1_ready), .req1_addr_i(req_addr[1]),
        .req1_op_i(req_op[1]), .req1_wdata_i(req_wdata[1]),
        .resp1_valid_o(resp1_valid), .resp1_ready_i(resp_ready[1]),
        .resp1_rdata_o(resp1_rdata), .resp1_illegal_o(resp1_illegal),
        .csr_addr_o(csr_addr), .csr_rd_o(csr_rd), .csr_rdata_i(csr_rdata),
        .csr_nonexist_i(csr_nonexist), .csr_we_o(csr_we), .csr_wdata_o(csr_wdata)
    );

    // Second instance with the debug privilege bypass disabled; only port 1 is exercised.
    logic        nb_valid1 = 1'b0;
    logic [11:0] nb_addr1 = 12'h000;
    logic [1:0]  nb_priv = 2'b00;
    logic        nb_ready0, nb_ready1, nb_rv0, nb_rv1, nb_ill0, nb_ill1;
    logic        nb_rd, nb_we;
    logic [63:0] nb_rdata0, nb_rdata1, nb_wdata;
    logic [11:0] nb_csr_addr;

    csr_access_arbiter #(.XLEN(64), .DBG_PRV_BYPASS(1'b0)) dut_nb (
        .clk_i(clk), .arst_i(arst_i), .priv_i(nb_priv),
        .req0_valid_i(1'b0), .req0_ready_o(nb_ready0), .req0_addr_i(12'h000),
        .req0_op_i(2'b00), .req0_wdata_i(64'h0),
        .resp0_valid_o(nb_rv0), .resp0_ready_i(1'b1),
        .resp0_rdata_o(nb_rdata0), .resp0_illegal_o(nb_ill0),
        .req1_valid_i(nb_valid1), .req1_ready_o(nb_ready1), .req1_addr_i(nb_addr1),
        .req1_op_i(2'b00), .req1_wdata_i(64'h0),
        .resp1_valid_o(nb_rv1), .resp1_ready_i(1'b1),
        .resp1_rdata_o(nb_rdata1), .resp1_illegal_o(nb_ill1),
        .csr_addr_o(nb_csr_addr), .csr_rd_o(nb_rd), .csr_rdata_i(64'h1234),
        .csr_nonexist_i(1'b0), .csr_we_o(nb_we), .csr_wdata_o(nb_wdata)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic setCsr(input logic [11:0] a, input logic [63:0] v);
        env_mem[a] = v;
        model_mem[a] = v;
    endtask

    // The CSR file behind the DUT: it only ever changes through the DUT write strobe.
    always @(negedge clk) begin
        if (csr_we) begin
            env_mem[csr_addr] = csr_wdata;
            we_total++;
        end
    end

    // Reference model: one access at a time, described as a timeline measured from acceptance.
    bit          m_busy = 1'b0;
    int          m_owner = 0, m_t = 0, m_last = 1, m_idle_from = 0, m_resp_at = 99;
    logic [1:0]  m_op = 2'b00;
    logic [11:0] m_addr = 12'h000;
    logic [63:0] m_wd = '0, m_old = '0;
    logic        m_ill = 1'b0, m_wr = 1'b0;

    always @(negedge clk) begin
        int g, ph;
        bit resp_on;
        logic e_rd, e_we;
        logic [11:0] e_addr;
        logic [63:0] e_wdata, e_rdata;
        if (!arst_i) begin
            checkOutput("rst_ready0", req0_ready, 0);
            checkOutput("rst_ready1", req1_ready, 0);
            checkOutput("rst_resp0", {resp0_valid, resp0_illegal, resp0_rdata != 0}, 0);
            checkOutput("rst_resp1", {resp1_valid, resp1_illegal, resp1_rdata != 0}, 0);
            checkOutput("rst_csr", {csr_rd, csr_we, csr_addr != 0, csr_wdata != 0}, 0);
            m_busy = 1'b0; m_last = 1; m_idle_from = 0;
        end else begin
            g = -1; ph = cyc - m_t; resp_on = 1'b0;
            e_rd = 1'b0; e_we = 1'b0; e_addr = 12'h000; e_wdata = '0; e_rdata = '0;
            if (!m_busy && cyc >= m_idle_from) begin
                if (req_valid[0] && req_valid[1]) g = (m_last == 0) ? 1 : 0;
                else if (req_valid[0]) g = 0;
                else if (req_valid[1]) g = 1;
            end
            if (m_busy && ph == 1) begin
                e_rd = 1'b1; e_addr = m_addr;
                m_old = model_mem[m_addr];
                m_ill = (m_addr == NONEXIST_ADDR) || (m_op != 2'b00 && m_addr[11:10] == 2'b11)
                        || (m_owner == 0 && m_addr[9:8] > priv);
                m_wr = !m_ill && m_op != 2'b00;
                m_resp_at = m_wr ? 3 : 2;
            end
            if (m_busy && ph == 2 && m_wr) begin
                e_we = 1'b1; e_addr = m_addr;
                e_wdata = (m_op == 2'b01) ? m_wd : (m_op == 2'b10) ? (m_old | m_wd) : (m_old & ~m_wd);
            end
            if (m_busy && ph >= 2 && ph >= m_resp_at) begin
                resp_on = 1'b1;
                e_rdata = m_ill ? 64'h0 : m_old;
            end
            checkOutput("ready0", req0_ready, g == 0);
            checkOutput("ready1", req1_ready, g == 1);
            checkOutput("resp0_valid", resp0_valid, resp_on && m_owner == 0);
            checkOutput("resp1_valid", resp1_valid, resp_on && m_owner == 1);
            checkOutput("resp0_rdata", resp0_rdata, (resp_on && m_owner == 0) ? e_rdata : 64'h0);
            checkOutput("resp1_rdata", resp1_rdata, (resp_on && m_owner == 1) ? e_rdata : 64'h0);
            checkOutput("resp0_illegal", resp0_illegal, resp_on && m_owner == 0 && m_ill);
            checkOutput("resp1_illegal", resp1_illegal, resp_on && m_owner == 1 && m_ill);
            checkOutput("csr_rd", csr_rd, e_rd);
            checkOutput("csr_we", csr_we, e_we);
            checkOutput("csr_addr", csr_addr, e_addr);
            checkOutput("csr_wdata", csr_wdata, e_wdata);
            if (g >= 0) begin
                m_busy = 1'b1; m_owner = g; m_t = cyc; m_last = g; m_resp_at = 99;
                m_op = req_op[g]; m_addr = req_addr[g]; m_wd = req_wdata[g];
            end else if (resp_on && resp_ready[m_owner]) begin
                m_busy = 1'b0; m_idle_from = cyc + 1;
            end
            if (e_we) model_mem[m_addr] = e_wdata;
        end
    end

    task automatic doAccess(input int p, input logic [1:0] op, input logic [11:0] a,
                            input logic [63:0] wd, output logic [63:0] rd, output logic ill,
                            output int lat, output int n_we, output int we_at,
                            output logic [63:0] we_data);
        int t0;
        bit done;
        rd = '0; ill = 1'b0; lat = -1; n_we = 0; we_at = -1; we_data = '0; t0 = 0;
        @(posedge clk); #1;
        req_valid[p] = 1'b1; req_op[p] = op; req_addr[p] = a; req_wdata[p] = wd;
        resp_ready[p] = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
                done = 1'b1; t0 = cyc;
            end
        end
        checkOutput("accept_in_time", done, 1);
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (csr_we) begin
                n_we++; we_at = cyc - t0; we_data = csr_wdata;
            end
            if (rv[p]) begin
                done = 1'b1; lat = cyc - t0; rd = rdat[p]; ill = rill[p];
            end
        end
        checkOutput("resp_in_time", done, 1);
        @(posedge clk);
    endtask

    task automatic applyStimulus();
        for (int p = 0; p < 2; p++) begin
            req_valid[p]  = ($urandom_range(0, 9) < 6);
            req_op[p]     = 2'($urandom_range(0, 3));
            req_addr[p]   = ADDRS[$urandom_range(0, 7)];
            req_wdata[p]  = {$urandom, $urandom};
            resp_ready[p] = ($urandom_range(0, 9) < 7);
        end
        case ($urandom_range(0, 2))
            0:       priv = 2'b00;
            1:       priv = 2'b01;
            default: priv = 2'b11;
        endcase
    endtask

    task automatic idleInputs();
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'b0; req_op[p] = 2'b00; req_addr[p] = 12'h000;
            req_wdata[p] = '0; resp_ready[p] = 1'b1;
        end
    endtask

    initial begin
        logic [63:0] rd, we_data, held;
        logic ill;
        int lat, n_we, we_at, we_before;
        int grants[$];
        int exp_g[6] = '{0, 1, 0, 1, 0, 1};
        bit done;

        idleInputs();
        for (int i = 0; i < 4096; i++) setCsr(12'(i), 64'h0);
        setCsr(12'hF14, 64'h5);
        setCsr(12'h340, 64'h11);
        repeat (2) @(negedge clk);
        #2 arst_i = 1'b1;

        // Arbitration fresh out of reset: port 0 first, then strict alternation.
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'b1; req_op[p] = 2'b00; req_addr[p] = 12'h340;
        end
        for (int i = 0; i < 80 && grants.size() < 6; i++) begin
            @(negedge clk);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
        end
        @(posedge clk); #1;
        idleInputs();
        checkOutput("grant_count", grants.size(), 6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("grant_%0d", i), (grants.size() > i) ? grants[i] : 9, exp_g[i]);
        repeat (6) @(posedge clk);

        // Response held back on port 0 must stay put and block port 1.
        #1;
        req_valid[0] = 1'b1; req_addr[0] = 12'h340;
        req_valid[1] = 1'b1; req_addr[1] = 12'h300;
        resp_ready[0] = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = rv[0];
        end
        checkOutput("hold_resp_seen", done, 1);
        held = rdat[0];
        checkOutput("hold_rdata", held, 64'h11);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", rv[0], 1);
            checkOutput("hold_stable", rdat[0], held);
            checkOutput("hold_no_p1", req1_ready, 0);
        end
        @(posedge clk); #1;
        resp_ready[0] = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                done = 1'b1;
                checkOutput("after_hold_grant_p1", req1_ready, 1);
            end
        end
        checkOutput("after_hold_accept", done, 1);
        @(posedge clk); #1;
        idleInputs();
        repeat (8) @(posedge clk);

        // Read-modify-write flavours with exact timing.
        doAccess(0, 2'b01, 12'h340, 64'hA5, rd, ill, lat, n_we, we_at, we_data);
        checkOutput("rw_we_count", n_we, 1);
        checkOutput("rw_we_cycle", we_at, 2);
        checkOutput("rw_we_data", we_data, 64'hA5);
        checkOutput("rw_rdata", rd, 64'h11);
        checkOutput("rw_illegal", ill, 0);
        checkOutput("rw_latency", lat, 3);
        setCsr(12'h300, 64'h3);
        doAccess(0, 2'b10, 12'h300, 64'h8, rd, ill, lat, n_we, we_at, we_data);
        checkOutput("rs_we_data", we_data, 64'hB);
        checkOutput("rs_rdata", rd, 64'h3);
        doAccess(0, 2'b11, 12'h300, 64'h1, rd, ill, lat, n_we, we_at, we_data);
        checkOutput("rc_we_data", we_data, 64'hA);
        checkOutput("rc_rdata", rd, 64'hB);

        // Read-only region and privilege checks.
        doAccess(0, 2'b01, 12'hF14, 64'hFF, rd, ill, lat, n_we, we_at, we_data);
        checkOutput("ro_we_count", n_we, 0);
        checkOutput("ro_illegal", ill, 1);
        checkOutput("ro_rdata", rd, 64'h0);
        checkOutput("ro_latency", lat, 2);
        doAccess(0, 2'b00, 12'hF14, 64'h0, rd, ill, lat, n_we, we_at, we_data);
        checkOutput("hartid_illegal", ill, 0);
        checkOutput("hartid_rdata", rd, 64'h5);
        priv = 2'b00;
        doAccess(0, 2'b00, 12'h300, 64'h0, rd, ill, lat, n_we, we_at, we_data);
        checkOutput("u_p0_illegal", ill, 1);
        doAccess(1, 2'b00, 12'h300, 64'h0, rd, ill, lat, n_we, we_at, we_data);
        checkOutput("u_p1_bypass_illegal", ill, 0);
        checkOutput("u_p1_bypass_rdata", rd, 64'hA);
        priv = 2'b11;

        // Debug port without bypass is privilege-checked like the commit port.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            nb_valid1 = 1'b1; nb_addr1 = (k == 0) ? 12'h300 : 12'h000;
            done = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                @(negedge clk);
                if (nb_ready1) done = 1'b1;
            end
            @(posedge clk); #1 nb_valid1 = 1'b0;
            done = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                @(negedge clk);
                if (nb_rv1) begin
                    done = 1'b1;
                    checkOutput(k == 0 ? "nb_u_illegal" : "nb_u_legal", nb_ill1, k == 0);
                    checkOutput("nb_rdata", nb_rdata1, (k == 0) ? 64'h0 : 64'h1234);
                end
            end
            checkOutput("nb_resp_in_time", done, 1);
        end

        // Reset while a write-bound access sits in READ.
        setCsr(12'h340, 64'h77);
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_op[0] = 2'b01; req_addr[0] = 12'h340; req_wdata[0] = 64'h1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = req0_ready;
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_in_read", csr_rd, 1);
        we_before = we_total;
        #1 arst_i = 1'b0;
        req_valid[1] = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready1", req1_ready, 0);
        checkOutput("reset_csr_we", csr_we, 0);
        checkOutput("reset_resp0", resp0_valid, 0);
        req_valid[1] = 1'b0;
        #2 arst_i = 1'b1;
        checkOutput("reset_no_write", we_total - we_before, 0);
        doAccess(0, 2'b00, 12'h340, 64'h0, rd, ill, lat, n_we, we_at, we_data);
        checkOutput("post_reset_rdata", rd, 64'h77);
        checkOutput("post_reset_latency", lat, 2);

        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            applyStimulus();
        end
        @(posedge clk); #1;
        idleInputs();
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
